// File: rtl/regfile_cmd_sequencer_if.sv
// Regfile command bus between micro-op decode, the command sequencer and the ALU.
// The master modport is the sequencer side; the slave modport is everything around it.
interface regfile_cmd_sequencer_if #(
   parameter int WIDTH       = 16,
   parameter int INDEX_WIDTH = 3
);
   logic                   i_req_valid;
   logic                   o_req_ready;
   logic [1:0]             i_req_op;
   logic [INDEX_WIDTH-1:0] i_sel_a;
   logic [INDEX_WIDTH-1:0] i_sel_b;
   logic [INDEX_WIDTH-1:0] i_sel_c;
   logic [3:0]             o_rf_cmd;
   logic [INDEX_WIDTH-1:0] o_rf_sel_a;
   logic [INDEX_WIDTH-1:0] o_rf_sel_b;
   logic [INDEX_WIDTH-1:0] o_rf_sel_c;
   logic [WIDTH-1:0]       i_rf_data;
   logic [WIDTH-1:0]       o_rf_wdata;
   logic [WIDTH-1:0]       o_op_a;
   logic [WIDTH-1:0]       o_op_b;
   logic                   o_alu_start;
   logic                   i_alu_done;
   logic [WIDTH-1:0]       i_alu_result;
   logic [WIDTH-1:0]       o_rdata;
   logic                   o_done;
   logic                   o_error;

   modport master (
      input  i_req_valid, i_req_op, i_sel_a, i_sel_b, i_sel_c,
      input  i_rf_data, i_alu_done, i_alu_result,
      output o_req_ready, o_rf_cmd, o_rf_sel_a, o_rf_sel_b, o_rf_sel_c,
      output o_rf_wdata, o_op_a, o_op_b, o_alu_start, o_rdata, o_done, o_error
   );

   modport slave (
      output i_req_valid, i_req_op, i_sel_a, i_sel_b, i_sel_c,
      output i_rf_data, i_alu_done, i_alu_result,
      input  o_req_ready, o_rf_cmd, o_rf_sel_a, o_rf_sel_b, o_rf_sel_c,
      input  o_rf_wdata, o_op_a, o_op_b, o_alu_start, o_rdata, o_done, o_error
   );
endinterface

// File: rtl/regfile_cmd_sequencer.sv
// Regfile command sequencer: accepts one micro-op per handshake, expands it into one
// regfile command per cycle, captures read data and exchanges operands with the ALU.
// All outputs are registered; the command for a cycle is chosen from the state entered.
module regfile_cmd_sequencer #(
   parameter int WIDTH       = 16,
   parameter int INDEX_WIDTH = 3,
   parameter int ALU_TIMEOUT = 15
) (
   input logic                     clk,
   input logic                     rst_n,
   regfile_cmd_sequencer_if.master bus
);
   localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

   localparam logic [3:0] CMD_NOP      = 4'd0;
   localparam logic [3:0] CMD_READA    = 4'd1;
   localparam logic [3:0] CMD_READB    = 4'd2;
   localparam logic [3:0] CMD_LATCHC   = 4'd3;
   localparam logic [3:0] CMD_LATCHSEL = 4'd4;
   localparam logic [3:0] CMD_READSP   = 4'd5;
   localparam logic [3:0] CMD_READF    = 4'd6;
   localparam logic [3:0] CMD_SPINC    = 4'd7;
   localparam logic [3:0] CMD_SPDEC    = 4'd8;

   localparam logic [1:0] OP_ALU  = 2'd0;
   localparam logic [1:0] OP_PUSH = 2'd1;
   localparam logic [1:0] OP_POP  = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_SEL, S_RDA, S_RDB, S_CAPB, S_WAIT, S_WRC,
      S_SPDEC, S_RDSP, S_RDF, S_CAP, S_SPINC, S_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       cmd_next;
   logic             error_next;
   logic [1:0]       op;
   logic [CNT_W-1:0] wait_cnt;
   logic             accept;
   logic             alu_done_ok;
   logic             timeout;

   // A request is taken only while idle; ALU done in the start cycle is stale and ignored.
   assign accept      = (state == S_IDLE) && bus.i_req_valid;
   assign alu_done_ok = bus.i_alu_done && !bus.o_alu_start;
   assign timeout     = (wait_cnt == CNT_W'(ALU_TIMEOUT - 1));

   // State register; synchronous reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the command and error flag that go with the state being entered.
   always_comb begin
      state_next = state;
      cmd_next   = CMD_NOP;
      error_next = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_req_valid) begin
               case (bus.i_req_op)
                  OP_ALU:  state_next = S_SEL;
                  OP_PUSH: state_next = S_SPDEC;
                  OP_POP:  state_next = S_RDSP;
                  default: state_next = S_RDF;
               endcase
            end
         end
         S_SEL:   state_next = S_RDA;
         S_RDA:   state_next = S_RDB;
         S_RDB:   state_next = S_CAPB;
         S_CAPB:  state_next = S_WAIT;
         S_WAIT: begin
            if (alu_done_ok) begin
               state_next = S_WRC;
            end else if (timeout) begin
               state_next = S_DONE;
               error_next = 1'b1;
            end
         end
         S_WRC:   state_next = S_DONE;
         S_SPDEC: state_next = S_RDSP;
         S_RDSP:  state_next = S_CAP;
         S_RDF:   state_next = S_CAP;
         S_CAP:   state_next = (op == OP_POP) ? S_SPINC : S_DONE;
         S_SPINC: state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      case (state_next)
         S_SEL:   cmd_next = CMD_LATCHSEL;
         S_RDA:   cmd_next = CMD_READA;
         S_RDB:   cmd_next = CMD_READB;
         S_WRC:   cmd_next = CMD_LATCHC;
         S_SPDEC: cmd_next = CMD_SPDEC;
         S_RDSP:  cmd_next = CMD_READSP;
         S_RDF:   cmd_next = CMD_READF;
         S_SPINC: cmd_next = CMD_SPINC;
         default: cmd_next = CMD_NOP;
      endcase
   end

   // Registered outputs, request capture, read-data capture and the ALU wait counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.o_rf_cmd    <= CMD_NOP;
         bus.o_req_ready <= 1'b1;
         bus.o_done      <= 1'b0;
         bus.o_error     <= 1'b0;
         bus.o_alu_start <= 1'b0;
         bus.o_rf_sel_a  <= INDEX_WIDTH'(0);
         bus.o_rf_sel_b  <= INDEX_WIDTH'(0);
         bus.o_rf_sel_c  <= INDEX_WIDTH'(0);
         bus.o_rf_wdata  <= WIDTH'(0);
         bus.o_op_a      <= WIDTH'(0);
         bus.o_op_b      <= WIDTH'(0);
         bus.o_rdata     <= WIDTH'(0);
         op              <= OP_ALU;
         wait_cnt        <= CNT_W'(0);
      end else begin
         bus.o_rf_cmd    <= cmd_next;
         bus.o_req_ready <= (state_next == S_IDLE);
         bus.o_done      <= (state_next == S_DONE);
         bus.o_error     <= error_next;
         bus.o_alu_start <= (state == S_CAPB);
         if (accept) begin
            op <= bus.i_req_op;
            if (bus.i_req_op == OP_ALU) begin
               bus.o_rf_sel_a <= bus.i_sel_a;
               bus.o_rf_sel_b <= bus.i_sel_b;
               bus.o_rf_sel_c <= bus.i_sel_c;
            end
         end
         if (state == S_RDB) begin
            bus.o_op_a <= bus.i_rf_data;
         end
         if (state == S_CAPB) begin
            bus.o_op_b <= bus.i_rf_data;
            wait_cnt   <= CNT_W'(0);
         end
         if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (alu_done_ok) begin
               bus.o_rf_wdata <= bus.i_alu_result;
            end
         end
         if (state == S_CAP) begin
            bus.o_rdata <= bus.i_rf_data;
         end
      end
   end
endmodule
